// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// big-endian, four byte writes per word, starting at BASE.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int                PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0]   PTR_BASE = PTR_W'(BASE);
  localparam logic [ADDR_W:0]   PTR_ONE  = 1;
  localparam logic [ADDR_W-2:0] CNT_ONE  = 1;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [1:0]        idx;
  logic [23:0]       word_q;
  logic              last_q;
  logic              full;

  // Byte that follows byte index i; byte 0 is taken straight from word_in.
  function automatic logic [7:0] next_byte(input logic [23:0] w, input logic [1:0] i);
    case (i)
      2'd0:    next_byte = w[23:16];
      2'd1:    next_byte = w[15:8];
      default: next_byte = w[7:0];
    endcase
  endfunction

  // ptr carries one extra bit so that reaching the top of memory reads as full.
  assign full       = ptr[ADDR_W];
  assign word_ready = (state == S_WAIT_WORD) && !full;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= PTR_BASE;
      idx        <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow   <= 1'b0;
            word_count <= '0;
            ptr        <= PTR_BASE;
            state      <= S_WAIT_WORD;
          end
        end

        S_WAIT_WORD: begin
          if (word_valid && !full) begin
            // The first byte is issued on the accepting edge so the write
            // burst occupies exactly the four WRITE cycles.
            word_q    <= word_in[23:0];
            last_q    <= word_last;
            idx       <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= ptr[ADDR_W-1:0];
            mem_wdata <= word_in[31:24];
            ptr       <= ptr + PTR_ONE;
            state     <= S_WRITE;
          end else if (word_valid) begin
            overflow <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end

        S_WRITE: begin
          if (idx != 2'd3) begin
            mem_addr  <= ptr[ADDR_W-1:0];
            mem_wdata <= next_byte(word_q, idx);
            ptr       <= ptr + PTR_ONE;
            idx       <= idx + 2'd1;
          end else begin
            mem_we     <= 1'b0;
            word_count <= word_count + CNT_ONE;
            if (last_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT_WORD;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
